interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Prioritised, maskable 8-line interrupt controller that sits directly upstream of the CPU core. It collects raw peripheral interrupt lines, latches them as pending, selects the highest-priority eligible source and presents a single request plus a 3-bit vector to the CPU through a request/acknowledge handshake. Mask, mode and pending state are memory-mapped on the CPU's 16-bit data/address bus, so firmware configures and clears it with ordinary loads and stores.

## Interface
- BASE_ADDR, 16'hFF00, base of the 4-word register window; BASE_ADDR[1:0] must be 0.
- RESET_MODE, 8'hFF, reset value of MODE; bit = 1 means edge-triggered, 0 means level-triggered.

Ports (name, direction, width, meaning):
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- irq_lines  input  8  raw peripheral requests, asynchronous to clk.
- address_bus  input  16  CPU address bus.
- data_bus  inout  16  CPU data bus; driven only during a selected read, otherwise 16'bz.
- r  input  1  CPU read strobe.
- w  input  1  CPU write strobe.
- irq_req  output  1  interrupt request to the CPU.
- irq_vector  output  3  index of the requested source; valid and stable while irq_req=1.
- irq_ack  input  1  one-cycle CPU acknowledge of the current request.
- irq_eoi  input  1  one-cycle end-of-interrupt pulse from the CPU (issued on return).

## Operation
- Select: sel = (address_bus[15:2] == BASE_ADDR[15:2]); reg = address_bus[1:0].
- Register map:
  - 0 PENDING: read; write-1-to-clear on bits [7:0].
  - 1 MASK: read/write; bit 1 = enabled.
  - 2 MODE: read/write.
  - 3 IN_SERVICE: read-only; writes ignored.
  - Reads return {8'h00, reg[7:0]}.
- Read: data_bus is driven combinationally while r && sel.
- Write: takes effect at posedge when w && sel && !r.
- Input path: irq_lines pass through a 2-flop synchronizer (s2), then s3 = s2 delayed one cycle.
- Edge mode: pending[i] is set when s2[i] && !s3[i].
- Level mode: pending[i] = s2[i] each cycle. A W1C write has no lasting effect while the line stays high.
- Set beats clear: an edge arriving in the same cycle as a W1C of that bit leaves pending=1.
- eligible = pending & MASK. Candidate c = the lowest set index of eligible; index 0 is the highest priority.
- Preemption: c is accepted only if IN_SERVICE is 0 or c < (lowest set index of IN_SERVICE).
- FSM:
  - IDLE: if a candidate is accepted, latch irq_vector=c and go to REQ.
  - REQ: irq_req=1.
    - On irq_ack: set IN_SERVICE[irq_vector]; clear pending[irq_vector] if that source is edge mode; go to IDLE.
    - Without ack, if eligible[irq_vector] drops (masked or cleared by software): withdraw and go to IDLE; no vector is lost, since the pending bit still reflects the source.
    - irq_vector does not change while in REQ, even if a higher-priority source arrives. The higher source is taken on the next IDLE pass.
- irq_eoi clears the lowest set bit of IN_SERVICE. An eoi with IN_SERVICE=0 is ignored.
- Simultaneous irq_ack and irq_eoi: the eoi clear is applied to the pre-ack IN_SERVICE, then the ack set is applied.
- irq_ack outside REQ is ignored.

## Timing
- Reset values: irq_req=0, irq_vector=0, PENDING=0, MASK=0, MODE=RESET_MODE, IN_SERVICE=0, synchronizer flops=0, FSM=IDLE, data_bus=Z.
- Reset applied mid-REQ drops irq_req on the next posedge.
- Edge on irq_lines to pending set: 3 posedges.
- Pending to irq_req high: 1 posedge, so 4 cycles from the raw edge with MASK set.
- irq_ack sampled at posedge N: irq_req=0 after N. A new request can assert at N+2 at the earliest (IDLE at N+1, REQ at N+2).
- MASK write at posedge N becomes effective for candidate selection in cycle N+1. A withdraw from REQ happens at posedge N+1.
- Read data is valid in the same cycle that r && sel is asserted; there is no wait state.

## Test plan
- Reset, write MASK=8'h04, pulse irq_lines[2] for 1 cycle -> irq_req=1 with irq_vector=2 four cycles after the edge; PENDING reads 16'h0004.
- Pending on lines 5 and 1, MASK=8'hFF -> vector=1. Then ack -> IN_SERVICE=8'h02, PENDING=8'h20, and no request for line 5 until eoi. After eoi -> request with vector=5.
- Line 3 in service, line 0 edge arrives -> irq_req with vector=0 (preemption). After ack, IN_SERVICE=8'h09. First eoi -> 8'h08; second eoi -> 8'h00.
- Level mode (MODE=8'h00), hold irq_lines[4] high, W1C PENDING bit 4 -> reads back 1. Drop the line -> PENDING[4]=0 two cycles later.
- In REQ with vector=6, write MASK=0 before ack -> irq_req=0 the cycle after the write; PENDING[6] is still 1.
- Edge on line 7 in the same cycle as a W1C of bit 7 -> PENDING[7]=1. Assert reset during REQ -> all outputs return to their reset values on the next posedge.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module      : interrupt_controller_if
// Description : CPU-side bus and interrupt handshake bundle for the 8-line
//               interrupt controller. The tri-state data bus is not part of
//               this bundle; it stays a direct inout port of the controller.
//   irq_lines   peripheral raw interrupt lines (asynchronous)
//   address_bus CPU address bus
//   r / w       CPU read / write strobes
//   irq_req     interrupt request to the CPU
//   irq_vector  index of the requested source
//   irq_ack     one-cycle acknowledge from the CPU
//   irq_eoi     one-cycle end-of-interrupt from the CPU
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if;
  logic [7:0]  irq_lines;
  logic [15:0] address_bus;
  logic        r;
  logic        w;
  logic        irq_req;
  logic [2:0]  irq_vector;
  logic        irq_ack;
  logic        irq_eoi;

  // CPU / peripheral side
  modport master (
    output irq_lines, address_bus, r, w, irq_ack, irq_eoi,
    input  irq_req, irq_vector
  );

  // Controller side
  modport slave (
    input  irq_lines, address_bus, r, w, irq_ack, irq_eoi,
    output irq_req, irq_vector
  );
endinterface

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Prioritised, maskable 8-line interrupt controller. Raw lines
//               are synchronised, latched as pending (edge or level per
//               line), filtered by MASK and IN_SERVICE, and the winner is
//               offered to the CPU through a req/ack handshake. PENDING,
//               MASK, MODE and IN_SERVICE are mapped at BASE_ADDR..+3.
//   clk       system clock
//   reset     synchronous active-high reset
//   bus       slave side of interrupt_controller_if (lines, address,
//             strobes, req/vector/ack/eoi)
//   data_bus  16-bit tri-state CPU data bus, driven only on a selected read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter logic [7:0]  RESET_MODE = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  interrupt_controller_if.slave  bus,
  inout  wire  [15:0]            data_bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [1:0] REG_PENDING    = 2'd0;
  localparam logic [1:0] REG_MASK       = 2'd1;
  localparam logic [1:0] REG_MODE       = 2'd2;
  localparam logic [1:0] REG_IN_SERVICE = 2'd3;

  logic [7:0]  sync1, sync2, sync3;
  logic [7:0]  pending_q, mask_q, mode_q, in_service_q;
  logic [0:0]  state_q;
  logic [2:0]  vector_q;

  logic        sel, wr_en, accept, ack_take;
  logic [1:0]  reg_idx;
  logic [7:0]  wdata, rise, pending, eligible;
  logic [7:0]  w1c, ack_clr, eoi_clr, pending_next, in_service_next;
  logic [2:0]  cand, isr_low;
  logic [15:0] rdata;
  logic        unused_data_hi;

  // Index of the lowest set bit (0 when none set; callers gate on != 0).
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    lowest_index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_index = i[2:0];
    end
  endfunction

  assign sel            = (bus.address_bus[15:2] == BASE_ADDR[15:2]);
  assign reg_idx        = bus.address_bus[1:0];
  assign wr_en          = bus.w && sel && !bus.r;
  assign wdata          = data_bus[7:0];
  assign unused_data_hi = ^data_bus[15:8];

  assign rise     = sync2 & ~sync3;
  // Level-mode lines are reported straight from the synchronizer so a W1C
  // can never hide a line that is still asserted.
  assign pending  = (pending_q & mode_q) | (sync2 & ~mode_q);
  assign eligible = pending & mask_q;
  assign cand     = lowest_index(eligible);
  assign isr_low  = lowest_index(in_service_q);
  // A lower index is a higher priority, so only strictly lower indices
  // may preempt whatever is already in service.
  assign accept   = (eligible != 8'h00) &&
                    ((in_service_q == 8'h00) || (cand < isr_low));
  assign ack_take = (state_q == ST_REQ) && bus.irq_ack;

  assign w1c      = (wr_en && reg_idx == REG_PENDING) ? wdata : 8'h00;
  assign ack_clr  = ack_take ? (8'h01 << vector_q) : 8'h00;
  // New edges win over any clear arriving in the same cycle.
  assign pending_next = ((rise | (pending_q & ~(w1c | ack_clr))) & mode_q) |
                        (sync2 & ~mode_q);

  // x & -x isolates the lowest set bit; eoi is applied before the ack set.
  assign eoi_clr         = bus.irq_eoi ? (in_service_q & (~in_service_q + 8'd1)) : 8'h00;
  assign in_service_next = (in_service_q & ~eoi_clr) | ack_clr;

  always_comb begin
    rdata = 16'h0000;
    case (reg_idx)
      REG_PENDING:    rdata = {8'h00, pending};
      REG_MASK:       rdata = {8'h00, mask_q};
      REG_MODE:       rdata = {8'h00, mode_q};
      REG_IN_SERVICE: rdata = {8'h00, in_service_q};
      default:        rdata = 16'h0000;
    endcase
  end

  assign data_bus = (bus.r && sel) ? rdata : 16'bz;

  assign bus.irq_req    = (state_q == ST_REQ);
  assign bus.irq_vector = vector_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= 8'h00;
      sync2        <= 8'h00;
      sync3        <= 8'h00;
      pending_q    <= 8'h00;
      mask_q       <= 8'h00;
      mode_q       <= RESET_MODE;
      in_service_q <= 8'h00;
      state_q      <= ST_IDLE;
      vector_q     <= 3'd0;
    end else begin
      sync1        <= bus.irq_lines;
      sync2        <= sync1;
      sync3        <= sync2;
      pending_q    <= pending_next;
      in_service_q <= in_service_next;
      if (wr_en && reg_idx == REG_MASK) mask_q <= wdata;
      if (wr_en && reg_idx == REG_MODE) mode_q <= wdata;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q  <= ST_REQ;
            vector_q <= cand;
          end
        end
        ST_REQ: begin
          // Withdraw if the offered source stopped being eligible; its
          // pending bit still records it for a later pass.
          if (bus.irq_ack || !eligible[vector_q]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller. Directed
//               scenarios with literal expectations, then randomized traffic
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_wdata;
  wire  [15:0] data_bus;

  interrupt_controller_if ifc ();

  interrupt_controller #(.BASE_ADDR(BASE), .RESET_MODE(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (ifc),
    .data_bus (data_bus)
  );

  // The CPU drives the data bus only for a write that is not also a read.
  assign data_bus = (ifc.w && !ifc.r) ? cpu_wdata : 16'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0] m_pend, m_mask, m_mode, m_isr;
  bit       m_req;
  int       m_vec;
  bit       m_valid = 1'b0;
  bit [7:0] seen[$];   // seen[0] newest sampled lines, seen[1] = synchronized

  function automatic int first_set(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit [7:0] model_view();
    bit [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_mode[i] ? m_pend[i] : seen[1][i];
    return v;
  endfunction

  function automatic bit in_window(input logic [15:0] a);
    return a[15:2] == BASE[15:2];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_mask = 0; m_mode = 8'hFF; m_isr = 0;
      m_req = 0; m_vec = 0;
      seen = '{8'h00, 8'h00, 8'h00};
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit [7:0] pv, elig, sync_now, sync_old;
      int cand, low_isr, idx;
      bit wr, acked;
      sync_now = seen[1];
      sync_old = seen[2];
      pv       = model_view();
      elig     = pv & m_mask;
      cand     = first_set(elig);
      low_isr  = first_set(m_isr);
      wr       = ifc.w && !ifc.r && in_window(ifc.address_bus);
      idx      = int'(ifc.address_bus[1:0]);
      acked    = m_req && ifc.irq_ack;
      for (int i = 0; i < 8; i++) begin
        if (m_mode[i]) begin
          if (sync_now[i] && !sync_old[i]) m_pend[i] = 1'b1;
          else if ((wr && idx == 0 && cpu_wdata[i]) || (acked && m_vec == i)) m_pend[i] = 1'b0;
        end else begin
          m_pend[i] = sync_now[i];
        end
      end
      if (ifc.irq_eoi && low_isr >= 0) m_isr[low_isr] = 1'b0;
      if (acked) m_isr[m_vec] = 1'b1;
      if (wr && idx == 1) m_mask = cpu_wdata[7:0];
      if (wr && idx == 2) m_mode = cpu_wdata[7:0];
      if (m_req) begin
        if (acked || !elig[m_vec]) m_req = 1'b0;
      end else if (cand >= 0 && (low_isr < 0 || cand < low_isr)) begin
        m_req = 1'b1;
        m_vec = cand;
      end
      seen.push_front(ifc.irq_lines);
      void'(seen.pop_back());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("irq_req", {31'd0, ifc.irq_req}, {31'd0, m_req});
      if (m_req) chk("irq_vector", {29'd0, ifc.irq_vector}, m_vec);
      if (ifc.r && in_window(ifc.address_bus)) begin
        bit [7:0] exp;
        case (ifc.address_bus[1:0])
          2'd0:    exp = model_view();
          2'd1:    exp = m_mask;
          2'd2:    exp = m_mode;
          default: exp = m_isr;
        endcase
        chk("read_data", {16'd0, data_bus}, {24'd0, exp});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_reg(input logic [1:0] idx, input logic [15:0] d);
    ifc.address_bus = BASE | {14'd0, idx};
    cpu_wdata = d;
    ifc.w = 1'b1;
    cyc();
    ifc.w = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] idx, input logic [15:0] exp);
    ifc.address_bus = BASE | {14'd0, idx};
    ifc.r = 1'b1;
    #1;
    chk(name, {16'd0, data_bus}, {16'd0, exp});
    ifc.r = 1'b0;
  endtask

  task automatic pulse_lines(input logic [7:0] v);
    ifc.irq_lines = v;
    cyc();
    ifc.irq_lines = 8'h00;
  endtask

  task automatic ack();
    ifc.irq_ack = 1'b1;
    cyc();
    ifc.irq_ack = 1'b0;
  endtask

  task automatic eoi();
    ifc.irq_eoi = 1'b1;
    cyc();
    ifc.irq_eoi = 1'b0;
  endtask

  task automatic req_chk(input string name, input logic req, input logic [2:0] vec);
    chk({name, "_req"}, {31'd0, ifc.irq_req}, {31'd0, req});
    if (req) chk({name, "_vec"}, {29'd0, ifc.irq_vector}, {29'd0, vec});
  endtask

  initial begin
    reset = 1'b1;
    cpu_wdata = 16'h0000;
    ifc.irq_lines = 8'h00; ifc.address_bus = 16'h0000;
    ifc.r = 1'b0; ifc.w = 1'b0; ifc.irq_ack = 1'b0; ifc.irq_eoi = 1'b0;
    cyc(2);
    reset = 1'b0;

    // Reset state
    chk("rst_req", {31'd0, ifc.irq_req}, 32'd0);
    chk("rst_vec", {29'd0, ifc.irq_vector}, 32'd0);
    read_chk("rst_pending", 2'd0, 16'h0000);
    read_chk("rst_mask",    2'd1, 16'h0000);
    read_chk("rst_mode",    2'd2, 16'h00FF);
    read_chk("rst_isr",     2'd3, 16'h0000);

    // Single edge on line 2: request four posedges after the edge
    write_reg(2'd1, 16'h0004);
    pulse_lines(8'h04);
    cyc(2);
    req_chk("s1_early", 1'b0, 3'd0);
    cyc();
    req_chk("s1", 1'b1, 3'd2);
    read_chk("s1_pending", 2'd0, 16'h0004);
    chk("model_pend_s1", {24'd0, m_pend}, 32'h04);
    ack();
    req_chk("s1_after_ack", 1'b0, 3'd0);
    read_chk("s1_isr", 2'd3, 16'h0004);
    eoi();
    read_chk("s1_isr_eoi", 2'd3, 16'h0000);

    // Lines 5 and 1 together: 1 wins, 5 waits for eoi
    write_reg(2'd1, 16'h00FF);
    pulse_lines(8'h22);
    cyc(3);
    req_chk("s2", 1'b1, 3'd1);
    ack();
    read_chk("s2_isr", 2'd3, 16'h0002);
    read_chk("s2_pending", 2'd0, 16'h0020);
    cyc(3);
    req_chk("s2_blocked", 1'b0, 3'd0);
    eoi();
    cyc();
    req_chk("s2_after_eoi", 1'b1, 3'd5);
    ack();
    eoi();
    read_chk("s2_isr_clr", 2'd3, 16'h0000);

    // Preemption: line 0 while line 3 in service
    pulse_lines(8'h08);
    cyc(3);
    req_chk("s3_l3", 1'b1, 3'd3);
    ack();
    pulse_lines(8'h01);
    cyc(3);
    req_chk("s3_preempt", 1'b1, 3'd0);
    ack();
    read_chk("s3_isr", 2'd3, 16'h0009);
    chk("model_isr_s3", {24'd0, m_isr}, 32'h09);
    eoi();
    read_chk("s3_isr_eoi1", 2'd3, 16'h0008);
    eoi();
    read_chk("s3_isr_eoi2", 2'd3, 16'h0000);

    // Level mode: W1C cannot clear a held line
    write_reg(2'd1, 16'h0000);
    write_reg(2'd2, 16'h0000);
    ifc.irq_lines = 8'h10;
    cyc(3);
    write_reg(2'd0, 16'h0010);
    read_chk("s4_w1c_held", 2'd0, 16'h0010);
    ifc.irq_lines = 8'h00;
    cyc();
    read_chk("s4_drop1", 2'd0, 16'h0010);
    cyc();
    read_chk("s4_drop2", 2'd0, 16'h0000);
    write_reg(2'd2, 16'h00FF);

    // Withdraw on mask while in REQ
    write_reg(2'd1, 16'h0040);
    pulse_lines(8'h40);
    cyc(3);
    req_chk("s5", 1'b1, 3'd6);
    write_reg(2'd1, 16'h0000);
    req_chk("s5_write_cycle", 1'b1, 3'd6);
    cyc();
    req_chk("s5_withdrawn", 1'b0, 3'd0);
    read_chk("s5_pending", 2'd0, 16'h0040);
    write_reg(2'd0, 16'h0040);
    read_chk("s5_w1c", 2'd0, 16'h0000);

    // Set beats clear on line 7
    pulse_lines(8'h80);
    cyc(4);
    read_chk("s6_pend_pre", 2'd0, 16'h0080);
    pulse_lines(8'h80);
    cyc();
    write_reg(2'd0, 16'h0080);
    read_chk("s6_set_beats_clr", 2'd0, 16'h0080);
    chk("model_pend_s6", {24'd0, m_pend}, 32'h80);

    // Reset in the middle of a request
    write_reg(2'd1, 16'h0080);
    cyc();
    req_chk("s6_req", 1'b1, 3'd7);
    reset = 1'b1;
    cyc();
    req_chk("s6_rst", 1'b0, 3'd0);
    chk("s6_rst_vec", {29'd0, ifc.irq_vector}, 32'd0);
    read_chk("s6_rst_pending", 2'd0, 16'h0000);
    read_chk("s6_rst_mask",    2'd1, 16'h0000);
    read_chk("s6_rst_mode",    2'd2, 16'h00FF);
    read_chk("s6_rst_isr",     2'd3, 16'h0000);
    reset = 1'b0;

    // Randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) ifc.irq_lines[b] = ~ifc.irq_lines[b];
      if ($urandom_range(0, 7) == 0) ifc.address_bus = 16'($urandom());
      else ifc.address_bus = BASE | 16'($urandom_range(0, 3));
      ifc.r       = ($urandom_range(0, 3) == 0);
      ifc.w       = ($urandom_range(0, 3) == 0);
      cpu_wdata   = 16'($urandom());
      ifc.irq_ack = ifc.irq_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      ifc.irq_eoi = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    ifc.r = 1'b0; ifc.w = 1'b0; ifc.irq_ack = 1'b0; ifc.irq_eoi = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
